midi_voice_allocator: RTL and testbench
=======================================

# midi_voice_allocator

Polyphonic successor to the single-note MIDI data processor: it accepts the same 32-bit decoded MIDI words with a `data_ready` strobe and tracks up to `NUM_VOICES` simultaneous notes instead of one. It filters by MIDI channel, allocates note-on events to free voices, releases them on note-off, and steals the oldest voice when all are busy. Registered per-voice pitch/velocity/active outputs feed the tone generators directly.

## Interface

- `NUM_VOICES`, default 4: number of voice slots; legal values 2–16.
- `MIDI_CHANNEL`, default 0: channel (0–15) accepted when `OMNI` = 0.
- `OMNI`, default 0: when 1, all channels are accepted.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `data_ready`  in  1  one-cycle strobe; `MIDI_data` is valid on this cycle.
- `MIDI_data`  in  32  `[31:24]` unused, `[23:16]` status, `[15:8]` data1 (pitch/controller), `[7:0]` data2 (velocity/value).
- `voice_pitch`  out  8*NUM_VOICES  voice v at `[8v+7:8v]`; `8'hFF` when idle.
- `voice_velocity`  out  7*NUM_VOICES  voice v at `[7v+6:7v]`; 0 when idle.
- `voice_active`  out  NUM_VOICES  bit v high while voice v sounds.
- `note_stolen`  out  1  one-cycle pulse when a note-on evicted an active voice.

## Operation

- Decode: status high nibble = message type, low nibble = channel. Messages on rejected channels and unlisted types are ignored (no state change).
- Note-on (`0x9n`, velocity ≠ 0):
  - Pitch already held by voice v: retrigger v (new velocity; v becomes newest).
  - Else if any voice free: allocate the lowest-index free voice.
  - Else steal the oldest voice, load the new pitch/velocity, pulse `note_stolen`.
- Note-off (`0x8n`), or note-on with velocity 0: the voice holding that pitch goes idle (pitch `FF`, velocity 0, active 0). If no voice holds the pitch, nothing changes.
- All-notes-off (`0xBn`, data1 = 123): all voices go idle.
- Age tracking: each active voice has a rank 0..NUM_VOICES-1, where 0 is newest.
  - Allocate: all active ranks +1; the new voice gets rank 0.
  - Retrigger or steal voice with rank r: ranks < r get +1; that voice gets rank 0.
  - Release voice with rank r: ranks > r get −1.
  - Active ranks are always a permutation of 0..k-1, where k is the active count.
- Velocity output is data2[6:0]; data1 bit 7 is passed through unchanged.

## Timing

- Reset: all `voice_pitch` = `FF`, `voice_velocity` = 0, `voice_active` = 0, `note_stolen` = 0, all ranks cleared.
- Latency: outputs update on the clock edge that samples `data_ready` high and are visible the following cycle. `note_stolen` is high for exactly that one cycle.
- `data_ready` on consecutive cycles: every word is processed in order, one per cycle, with no drops.
- `data_ready` low: state holds and `MIDI_data` is don't-care.
- `rst` takes priority over a simultaneous `data_ready`; the word is discarded.
- All voices full and a note-on arrives for a held pitch: this is a retrigger, not a steal; no pulse.

## Structure

- Package `midi_pkg`:
  - Constants `MIDI_NOTE_OFF` = 4'h8, `MIDI_NOTE_ON` = 4'h9, `MIDI_CTRL` = 4'hB, `CC_ALL_NOTES_OFF` = 8'd123, `IDLE_PITCH` = 8'hFF.
  - Enum `midi_msg_t` {MSG_NONE, MSG_ON, MSG_OFF, MSG_ALL_OFF}.
- Sub-module `midi_msg_decode`: combinational. Inputs are word, valid, and channel parameters; outputs are `midi_msg_t`, pitch, and velocity. It folds velocity-0 note-on into MSG_OFF.
- Top level holds voice registers, rank registers, match/free/oldest search, and update logic.

## Test plan

Defaults: NUM_VOICES = 4, MIDI_CHANNEL = 0, OMNI = 0.

1. Reset, then note-on `0x00903C64` → voice0 pitch `3C`, velocity `64`, active `0001`; voices 1–3 pitch `FF`.
2. Note-ons for pitches 3C, 40, 43, 48, then note-on 4C → voice0 (oldest) becomes `4C`, `note_stolen` high for one cycle, active `1111`.
3. From case 2, note-off `0x00804000`, then note-on 3E → voice1 freed, then reused with `3E`; no steal pulse.
4. Note-on `0x00913C64` (channel 1) → no change. Rebuild with OMNI = 1 → voice0 = `3C`.
5. Note-on `0x00903C00` after 3C is held → voice0 released. Then `0x00B07B00` with three voices active → all idle, pitch `FF`.
6. `data_ready` asserted with 3C on, and `rst` asserted on the same cycle → all outputs at reset values next cycle.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI message constants and the decoded message type
package midi_pkg;
   localparam logic [3:0] MIDI_NOTE_OFF    = 4'h8;
   localparam logic [3:0] MIDI_NOTE_ON     = 4'h9;
   localparam logic [3:0] MIDI_CTRL        = 4'hB;
   localparam logic [7:0] CC_ALL_NOTES_OFF = 8'd123;
   localparam logic [7:0] IDLE_PITCH       = 8'hFF;
   typedef enum logic [1:0] {MSG_NONE, MSG_ON, MSG_OFF, MSG_ALL_OFF} midi_msg_t;
endpackage

// File: rtl/midi_msg_decode.sv
// midi_msg_decode: classifies a MIDI word into on/off/all-off after channel filtering
module midi_msg_decode
   import midi_pkg::*;
#(
   parameter int MIDI_CHANNEL = 0,
   parameter bit OMNI         = 1'b0
) (
   input  logic [31:0] word,
   input  logic        valid,
   output midi_msg_t   msg,
   output logic [7:0]  pitch,
   output logic [6:0]  velocity
);
   logic [3:0] msg_type;
   logic [3:0] channel;
   logic       ch_ok;
   logic       unused_bits;
   assign msg_type    = word[23:20];
   assign channel     = word[19:16];
   assign ch_ok       = OMNI || channel == 4'(MIDI_CHANNEL);
   assign pitch       = word[15:8];
   assign velocity    = word[6:0];
   assign unused_bits = ^{word[31:24], word[7]};
   // Velocity-0 note-on is folded into note-off here so the allocator sees one release path
   always_comb
      msg = (!valid || !ch_ok)                                   ? MSG_NONE :
            (msg_type == MIDI_NOTE_ON && velocity != 7'd0)       ? MSG_ON :
            (msg_type == MIDI_NOTE_ON || msg_type == MIDI_NOTE_OFF) ? MSG_OFF :
            (msg_type == MIDI_CTRL && pitch == CC_ALL_NOTES_OFF) ? MSG_ALL_OFF : MSG_NONE;
endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: polyphonic note-to-voice allocation with oldest-voice stealing
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter int NUM_VOICES   = 4,
   parameter int MIDI_CHANNEL = 0,
   parameter bit OMNI         = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    data_ready,
   input  logic [31:0]             MIDI_data,
   output logic [8*NUM_VOICES-1:0] voice_pitch,
   output logic [7*NUM_VOICES-1:0] voice_velocity,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic                    note_stolen
);
   localparam int RW = $clog2(NUM_VOICES);
   midi_msg_t           msg;
   logic [7:0]          msg_pitch;
   logic [6:0]          msg_vel;
   logic [7:0]          pitch_q [NUM_VOICES];
   logic [7:0]          pitch_d [NUM_VOICES];
   logic [6:0]          vel_q   [NUM_VOICES];
   logic [6:0]          vel_d   [NUM_VOICES];
   logic [RW-1:0]       rank_q  [NUM_VOICES];
   logic [RW-1:0]       rank_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] act_q, act_d;
   logic                stolen_q, stolen_d;
   logic                hit, any_free;
   logic [RW-1:0]       hit_idx, free_idx, old_idx, sel;
   logic [RW:0]         lim;

   midi_msg_decode #(.MIDI_CHANNEL(MIDI_CHANNEL), .OMNI(OMNI)) u_decode (
      .word     (MIDI_data),
      .valid    (data_ready),
      .msg      (msg),
      .pitch    (msg_pitch),
      .velocity (msg_vel)
   );

   // Lowest-index matching voice, lowest-index free voice, and the voice holding the oldest rank
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      any_free = 1'b0;
      free_idx = '0;
      old_idx  = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (act_q[v] && pitch_q[v] == msg_pitch) begin
            hit     = 1'b1;
            hit_idx = RW'(v);
         end
         if (!act_q[v]) begin
            any_free = 1'b1;
            free_idx = RW'(v);
         end
         if (act_q[v] && rank_q[v] == RW'(NUM_VOICES - 1))
            old_idx = RW'(v);
      end
   end

   // Voice and age updates; an allocate ages every active voice (lim above all ranks),
   // while retrigger/steal only ages voices newer than the chosen one
   always_comb begin
      pitch_d  = pitch_q;
      vel_d    = vel_q;
      rank_d   = rank_q;
      act_d    = act_q;
      stolen_d = 1'b0;
      sel      = hit ? hit_idx : any_free ? free_idx : old_idx;
      lim      = (hit || !any_free) ? {1'b0, rank_q[sel]} : (RW+1)'(NUM_VOICES);
      if (msg == MSG_ON) begin
         for (int v = 0; v < NUM_VOICES; v++)
            if (act_q[v] && RW'(v) != sel && {1'b0, rank_q[v]} < lim)
               rank_d[v] = rank_q[v] + 1'b1;
         pitch_d[sel] = msg_pitch;
         vel_d[sel]   = msg_vel;
         act_d[sel]   = 1'b1;
         rank_d[sel]  = '0;
         stolen_d     = !hit && !any_free;
      end else if (msg == MSG_OFF && hit) begin
         for (int v = 0; v < NUM_VOICES; v++)
            if (act_q[v] && rank_q[v] > rank_q[hit_idx])
               rank_d[v] = rank_q[v] - 1'b1;
         pitch_d[hit_idx] = IDLE_PITCH;
         vel_d[hit_idx]   = '0;
         act_d[hit_idx]   = 1'b0;
         rank_d[hit_idx]  = '0;
      end else if (msg == MSG_ALL_OFF) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            pitch_d[v] = IDLE_PITCH;
            vel_d[v]   = '0;
            rank_d[v]  = '0;
         end
         act_d = '0;
      end
   end

   // State registers; reset discards any word presented on the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            pitch_q[v] <= IDLE_PITCH;
            vel_q[v]   <= '0;
            rank_q[v]  <= '0;
         end
         act_q    <= '0;
         stolen_q <= 1'b0;
      end else begin
         pitch_q  <= pitch_d;
         vel_q    <= vel_d;
         rank_q   <= rank_d;
         act_q    <= act_d;
         stolen_q <= stolen_d;
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
      assign voice_pitch[8*g +: 8]    = pitch_q[g];
      assign voice_velocity[7*g +: 7] = vel_q[g];
   end
   assign voice_active = act_q;
   assign note_stolen  = stolen_q;
endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: table vectors, corner sequences and a random run against an age-queue model
module tb_midi_voice_allocator;
   logic        clk = 1'b0;
   logic        rst;
   logic        dr;
   logic [31:0] md;
   logic [31:0] vp0, vp1;
   logic [27:0] vv0, vv1;
   logic [3:0]  va0, va1;
   logic        ns0, ns1;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   midi_voice_allocator dut (
      .clk(clk), .rst(rst), .data_ready(dr), .MIDI_data(md),
      .voice_pitch(vp0), .voice_velocity(vv0), .voice_active(va0), .note_stolen(ns0)
   );
   midi_voice_allocator #(.OMNI(1'b1)) dut_omni (
      .clk(clk), .rst(rst), .data_ready(dr), .MIDI_data(md),
      .voice_pitch(vp1), .voice_velocity(vv1), .voice_active(va1), .note_stolen(ns1)
   );

   typedef struct {
      logic [31:0] w;
      logic [31:0] ep;
      logic [27:0] ev;
      logic [3:0]  ea;
      logic        es;
   } vec_t;
   vec_t tbl[16];

   function automatic logic [31:0] P(input logic [7:0] a, b, c, d);
      return {d, c, b, a};
   endfunction
   function automatic logic [27:0] V(input logic [6:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] ep, input logic [27:0] ev,
                      input logic [3:0] ea, input logic es);
      cmp({nm, " pitch"}, vp0, ep);
      cmp({nm, " vel"}, {4'h0, vv0}, {4'h0, ev});
      cmp({nm, " active"}, {28'h0, va0}, {28'h0, ea});
      cmp({nm, " stolen"}, {31'h0, ns0}, {31'h0, es});
   endtask

   // Reference model: voices plus an age list of voice indices, newest first
   logic [7:0] m_p[4];
   logic [6:0] m_v[4];
   logic       m_a[4];
   logic       m_st;
   int         ord[$];

   function automatic void m_reset();
      for (int v = 0; v < 4; v++) begin
         m_p[v] = 8'hFF; m_v[v] = 0; m_a[v] = 0;
      end
      m_st = 0;
      ord.delete();
   endfunction

   function automatic void m_drop(input int v);
      for (int i = 0; i < ord.size(); i++)
         if (ord[i] == v) begin ord.delete(i); break; end
   endfunction

   function automatic void m_apply(input logic [31:0] w);
      logic [3:0] ty = w[23:20];
      logic [7:0] d1 = w[15:8];
      logic [6:0] vel = w[6:0];
      int held = -1;
      int tgt = -1;
      m_st = 0;
      if (w[19:16] != 4'h0) return;
      for (int v = 0; v < 4; v++)
         if (held < 0 && m_a[v] && m_p[v] == d1) held = v;
      if (ty == 4'h9 && vel != 0) begin
         if (held >= 0) begin
            tgt = held;
            m_drop(tgt);
         end else begin
            for (int v = 0; v < 4; v++) if (tgt < 0 && !m_a[v]) tgt = v;
            if (tgt < 0) begin
               tgt = ord.pop_back();
               m_st = 1;
            end
         end
         ord.push_front(tgt);
         m_p[tgt] = d1; m_v[tgt] = vel; m_a[tgt] = 1;
      end else if (ty == 4'h8 || ty == 4'h9) begin
         if (held >= 0) begin
            m_drop(held);
            m_p[held] = 8'hFF; m_v[held] = 0; m_a[held] = 0;
         end
      end else if (ty == 4'hB && d1 == 8'd123) begin
         m_reset();
      end
   endfunction

   task automatic m_chk(input string nm);
      logic [31:0] ep;
      logic [27:0] ev;
      logic [3:0]  ea;
      for (int v = 0; v < 4; v++) begin
         ep[8*v +: 8] = m_p[v];
         ev[7*v +: 7] = m_v[v];
         ea[v]        = m_a[v];
      end
      chk(nm, ep, ev, ea, m_st);
   endtask

   task automatic send(input logic [31:0] w);
      @(negedge clk);
      dr = 1'b1;
      md = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      dr  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [3:0] ty, ch;
   logic [7:0] d1, d2;
   int         r;

   initial begin
      tbl[0]  = '{32'h00903C64, P(8'h3C, 8'hFF, 8'hFF, 8'hFF), V(7'h64, 0, 0, 0), 4'b0001, 1'b0};
      tbl[1]  = '{32'h00904064, P(8'h3C, 8'h40, 8'hFF, 8'hFF), V(7'h64, 7'h64, 0, 0), 4'b0011, 1'b0};
      tbl[2]  = '{32'h00904364, P(8'h3C, 8'h40, 8'h43, 8'hFF), V(7'h64, 7'h64, 7'h64, 0), 4'b0111, 1'b0};
      tbl[3]  = '{32'h00904864, P(8'h3C, 8'h40, 8'h43, 8'h48), V(7'h64, 7'h64, 7'h64, 7'h64), 4'b1111, 1'b0};
      tbl[4]  = '{32'h00904C50, P(8'h4C, 8'h40, 8'h43, 8'h48), V(7'h50, 7'h64, 7'h64, 7'h64), 4'b1111, 1'b1};
      tbl[5]  = '{32'h00804000, P(8'h4C, 8'hFF, 8'h43, 8'h48), V(7'h50, 0, 7'h64, 7'h64), 4'b1101, 1'b0};
      tbl[6]  = '{32'h00903E22, P(8'h4C, 8'h3E, 8'h43, 8'h48), V(7'h50, 7'h22, 7'h64, 7'h64), 4'b1111, 1'b0};
      tbl[7]  = '{32'h00913C64, P(8'h4C, 8'h3E, 8'h43, 8'h48), V(7'h50, 7'h22, 7'h64, 7'h64), 4'b1111, 1'b0};
      tbl[8]  = '{32'h00904C7F, P(8'h4C, 8'h3E, 8'h43, 8'h48), V(7'h7F, 7'h22, 7'h64, 7'h64), 4'b1111, 1'b0};
      tbl[9]  = '{32'h00904D10, P(8'h4C, 8'h3E, 8'h4D, 8'h48), V(7'h7F, 7'h22, 7'h10, 7'h64), 4'b1111, 1'b1};
      tbl[10] = '{32'h00904D00, P(8'h4C, 8'h3E, 8'hFF, 8'h48), V(7'h7F, 7'h22, 0, 7'h64), 4'b1011, 1'b0};
      tbl[11] = '{32'h00805500, P(8'h4C, 8'h3E, 8'hFF, 8'h48), V(7'h7F, 7'h22, 0, 7'h64), 4'b1011, 1'b0};
      tbl[12] = '{32'h00B07B00, 32'hFFFFFFFF, 28'h0, 4'b0000, 1'b0};
      tbl[13] = '{32'h00B07A00, 32'hFFFFFFFF, 28'h0, 4'b0000, 1'b0};
      tbl[14] = '{32'h00903C64, P(8'h3C, 8'hFF, 8'hFF, 8'hFF), V(7'h64, 0, 0, 0), 4'b0001, 1'b0};
      tbl[15] = '{32'h00903C00, 32'hFFFFFFFF, 28'h0, 4'b0000, 1'b0};

      rst = 1'b1;
      dr  = 1'b0;
      md  = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset", 32'hFFFFFFFF, 28'h0, 4'h0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         send(tbl[i].w);
         chk($sformatf("vec%0d", i), tbl[i].ep, tbl[i].ev, tbl[i].ea, tbl[i].es);
      end

      // Steal pulse lasts one cycle and state holds while data_ready is low
      send(32'h00903C01);
      send(32'h00903D02);
      send(32'h00903E03);
      send(32'h00903F04);
      send(32'h00904005);
      chk("steal", P(8'h40, 8'h3D, 8'h3E, 8'h3F), V(7'h05, 7'h02, 7'h03, 7'h04), 4'b1111, 1'b1);
      @(negedge clk);
      dr = 1'b0;
      md = 32'h00B07B00;
      @(posedge clk);
      #1;
      chk("hold", P(8'h40, 8'h3D, 8'h3E, 8'h3F), V(7'h05, 7'h02, 7'h03, 7'h04), 4'b1111, 1'b0);

      // Channel filter versus omni
      do_reset();
      send(32'h00913C64);
      chk("ch1_filtered", 32'hFFFFFFFF, 28'h0, 4'h0, 1'b0);
      cmp("omni pitch", vp1, P(8'h3C, 8'hFF, 8'hFF, 8'hFF));
      cmp("omni active", {28'h0, va1}, 32'h1);

      // Reset wins over a simultaneous word
      send(32'h00904064);
      chk("pre_rst", P(8'h40, 8'hFF, 8'hFF, 8'hFF), V(7'h64, 0, 0, 0), 4'b0001, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      dr  = 1'b1;
      md  = 32'h00903C64;
      @(posedge clk);
      #1;
      chk("rst_prio", 32'hFFFFFFFF, 28'h0, 4'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      dr  = 1'b0;

      // Random run against the model
      m_reset();
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         r  = int'($urandom % 8);
         ty = r < 4 ? 4'h9 : r < 6 ? 4'h8 : r == 6 ? 4'hB : 4'hA + 4'($urandom % 5);
         ch = ($urandom % 6 == 0) ? 4'($urandom) : 4'h0;
         d1 = (ty == 4'hB && $urandom % 2 == 0) ? 8'd123 : 8'h3C + 8'($urandom % 7);
         d2 = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom % 128);
         dr = ($urandom % 4) != 0;
         md = {8'($urandom), ty, ch, d1, d2};
         @(posedge clk);
         #1;
         if (dr) m_apply(md);
         else m_st = 0;
         m_chk($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
